// File: rtl/core_pkg.sv
// Shared MiniRiscV core definitions: bubble encoding, major opcodes and the IF/ID record.
package core_pkg;

    localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD  = 7'b000_0011;
    localparam logic [6:0] OP_R     = 7'b011_0011;
    localparam logic [6:0] OP_I     = 7'b001_0011;
    localparam logic [6:0] OP_J     = 7'b110_1111;
    localparam logic [6:0] OP_U     = 7'b011_0111;
    localparam logic [6:0] OP_ECALL = 7'b111_0011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        inst:  BUBBLE_INST,
        pc:    32'h0,
        pc4:   32'h0,
        valid: 1'b0
    };

endpackage

// File: rtl/pc_gen.sv
// PC register, fetch-valid flag and next-PC selection driving the instruction memory address.
module pc_gen
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [29:0]        redirect_word,
    input  logic               halt,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fetch_valid,
    output logic [IMEM_AW-1:0] imem_addr
);

    logic [31:0] pc_next;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = {redirect_word, 2'b00};
        end else if (!fetch_valid || stall || halt) begin
            pc_next = pc;
        end
    end

    assign imem_addr = pc_next[IMEM_AW+1:2];

    // pc always tracks pc_next: every hold case already selects pc in the mux.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
        end else begin
            pc          <= pc_next;
            fetch_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: pc_gen plus the IF/ID pipeline register and misaligned-redirect flag.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    input  logic               halt,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        if_id_inst,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               misalign_err
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    if_id_t      if_id;

    pc_gen #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW)
    ) u_pc_gen (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_word (redirect_target[31:2]),
        .halt          (halt),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .imem_addr     (imem_addr)
    );

    // Redirect beats stall: the wrong-path word must never survive into decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id        <= IF_ID_BUBBLE;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (redirect) begin
                if_id        <= IF_ID_BUBBLE;
                misalign_err <= |redirect_target[1:0];
            end else if (stall) begin
                if_id <= if_id;
            end else if (!fetch_valid || halt) begin
                if_id <= IF_ID_BUBBLE;
            end else begin
                if_id <= '{inst: imem_rdata, pc: pc, pc4: pc_plus4, valid: 1'b1};
            end
        end
    end

    assign if_id_inst  = if_id.inst;
    assign if_id_pc    = if_id.pc;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/halt/redirect/reset against a reference model.
module tb_fetch_stage;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic          halt = 1'b0;
    logic [31:0]   redirect_target = 32'h0;
    logic [31:0]   imem_rdata = 32'h0;
    logic [AW-1:0] imem_addr;
    logic [31:0]   if_id_inst;
    logic [31:0]   if_id_pc;
    logic [31:0]   if_id_pc4;
    logic          if_id_valid;
    logic          misalign_err;

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_fv;
    logic [31:0] m_inst;
    logic [31:0] m_ipc;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_inst      (if_id_inst),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_valid     (if_id_valid),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [AW-1:0] w);
        if (w == '0) return 32'h0050_0093;
        return {2'b10, w, ~w, 2'b11};
    endfunction

    // synchronous-read instruction memory, one cycle latency
    always @(posedge clk) imem_rdata <= inst_of(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_pc_next();
        if (redirect) return {redirect_target[31:2], 2'b00};
        if (!m_fv || stall || halt) return m_pc;
        return m_pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_fv = 1'b0;
        m_inst = 32'h0; m_ipc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_bubble();
        m_inst = 32'h0; m_ipc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        nxt = exp_pc_next();
        m_mis = 1'b0;
        if (redirect) begin
            model_bubble();
            m_mis = |redirect_target[1:0];
        end else if (stall) begin
            // hold everything
        end else if (!m_fv || halt) begin
            model_bubble();
        end else begin
            m_inst  = inst_of(m_pc[AW+1:2]);
            m_ipc   = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        m_pc = nxt;
        m_fv = 1'b1;
    endtask

    task automatic check_addr(input string tag);
        logic [31:0] nxt;
        nxt = exp_pc_next();
        chk(tag, {18'h0, imem_addr}, {18'h0, nxt[AW+1:2]});
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".inst"},  if_id_inst, m_inst);
        chk({tag, ".pc"},    if_id_pc, m_ipc);
        chk({tag, ".pc4"},   if_id_pc4, m_pc4);
        chk({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
        chk({tag, ".mis"},   {31'h0, misalign_err}, {31'h0, m_mis});
    endtask

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic cycle(input string tag);
        #1 check_addr({tag, ".addr"});
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic set_in(input logic s, input logic r, input logic [31:0] t, input logic h);
        stall = s; redirect = r; redirect_target = t; halt = h;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_reset();
        check_outs(tag);
        check_addr({tag, ".addr"});
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        // reset held three edges
        repeat (3) begin
            @(negedge clk);
            check_outs("rst");
            chk("rst.addr", {18'h0, imem_addr}, 32'h0);
        end
        rst = 1'b1;

        // first valid instruction after one priming edge
        cycle("prime");
        chk("prime.valid", {31'h0, if_id_valid}, 32'h0);
        cycle("first");
        chk("first.inst", if_id_inst, 32'h0050_0093);
        chk("first.pc4", if_id_pc4, 32'h4);
        cycle("seq1");
        cycle("seq2");
        chk("seq2.pc", if_id_pc, 32'h8);

        // stall holds IF/ID and the memory address
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        cycle("stall1");
        chk("stall1.addr", {18'h0, imem_addr}, 32'h3);
        cycle("stall2");
        chk("stall2.pc", if_id_pc, 32'h8);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        cycle("unstall");
        chk("unstall.pc", if_id_pc, 32'hC);

        // redirect overrides a concurrent stall
        set_in(1'b1, 1'b1, 32'h100, 1'b0);
        #1 chk("redir.addr", {18'h0, imem_addr}, 32'h40);
        cycle("redir");
        chk("redir.valid", {31'h0, if_id_valid}, 32'h0);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        cycle("redir_tgt");
        chk("redir_tgt.pc", if_id_pc, 32'h100);

        // misaligned redirect to the top of the address space, then wrap
        set_in(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        cycle("mis");
        chk("mis.err", {31'h0, misalign_err}, 32'h1);
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        cycle("mis_top");
        chk("mis_top.err", {31'h0, misalign_err}, 32'h0);
        chk("mis_top.pc4", if_id_pc4, 32'h0);
        cycle("wrap");
        chk("wrap.pc", if_id_pc, 32'h0);

        // halt at 0x20 drains the pipe, then resumes from the held pc
        set_in(1'b0, 1'b1, 32'h20, 1'b0);
        cycle("to20");
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) begin
            cycle("halt");
            chk("halt.valid", {31'h0, if_id_valid}, 32'h0);
        end
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        cycle("resume");
        chk("resume.pc", if_id_pc, 32'h20);
        cycle("run");

        // asynchronous reset mid-cycle
        async_reset("arst");
        chk("arst.valid", {31'h0, if_id_valid}, 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            case ($urandom_range(3))
                0: t = $urandom;
                1: t = {$urandom_range(32'h3FFF_FFFF), 2'b00};
                2: t = 32'hFFFF_FFF0 | $urandom_range(15);
                default: t = $urandom_range(255);
            endcase
            set_in($urandom_range(4) == 0, $urandom_range(8) == 0, t, $urandom_range(6) == 0);
            if ($urandom_range(60) == 0) async_reset("rnd_arst");
            else cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
